// File: rtl/ch1_sweep_ctl_pkg.sv
// Shared types for the channel-1 sweep sequencer.
// Contents: sequencer state and mode encodings, and the reload value used
// when the NR10 sweep period field is zero.
package apu_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CHECK, UPDATE} sweep_state_t;
  typedef enum logic {CALC, CHECK_ONLY} sweep_mode_t;

  localparam int SWEEP_PERIOD_ZERO_RELOAD = 8;

endpackage

// File: rtl/ch1_sweep_ctl_if.sv
// Control/status bundle between the sweep sequencer and the sweep datapath
// (shift register, 11-bit adder, shadow frequency register).
//   ch1_ld_shift   load shadow frequency into the shift register
//   ch1_shift_clk  shift register clock, one high cycle per bit
//   ch1_freq_upd1  write adder sum into shadow bits 10:8
//   ch1_freq_upd2  write adder sum into shadow bits 7:0
//   sum_ok         adder flag: 1 = no carry out of bit 10, or subtract mode
// master = sequencer, slave = datapath.
interface ch1_sweep_ctl_if;
  logic ch1_ld_shift;
  logic ch1_shift_clk;
  logic ch1_freq_upd1;
  logic ch1_freq_upd2;
  logic sum_ok;

  modport master (output ch1_ld_shift, ch1_shift_clk, ch1_freq_upd1, ch1_freq_upd2,
                  input  sum_ok);
  modport slave  (input  ch1_ld_shift, ch1_shift_clk, ch1_freq_upd1, ch1_freq_upd2,
                  output sum_ok);
endinterface

// File: rtl/ch1_sweep_ctl_sweep_timer.sv
// Sweep period timer: reload down-counter, period 0 reloads as 8.
//   clk, apu_reset  clock, synchronous active-high reset (count -> 0)
//   load            reload from period (channel trigger)
//   step            one serviced 128 Hz tick
//   period          NR10 sweep period field
//   expire          combinational strobe: step seen with count <= 1
// The counter is one bit wider than the period field so it can hold 8.
module sweep_timer
  import apu_pkg::*;
#(
  parameter int PERIOD_W = 3
) (
  input  logic                clk,
  input  logic                apu_reset,
  input  logic                load,
  input  logic                step,
  input  logic [PERIOD_W-1:0] period,
  output logic                expire
);
  localparam int CW = PERIOD_W + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] reload;

  assign reload = (period == '0) ? CW'(SWEEP_PERIOD_ZERO_RELOAD) : CW'(period);
  // A count of 0 (after reset) also expires on the first tick.
  assign expire = step & (cnt <= CW'(1));

  always_ff @(posedge clk) begin
    if (apu_reset)    cnt <= '0;
    else if (load)    cnt <= reload;
    else if (step)    cnt <= (cnt <= CW'(1)) ? reload : cnt - CW'(1);
  end
endmodule

// File: rtl/ch1_sweep_ctl.sv
// Channel-1 frequency-sweep sequencer.
// Runs LOAD -> SHIFT(2n) -> CHECK -> (UPDATE) on the datapath after a
// trigger (check only) or a sweep timer expiry (calculate and write back),
// and requests channel disable when the adder overflows.
// Ports:
//   clk, apu_reset   clock, synchronous active-high reset
//   sweep_tick       128 Hz strobe from the frame sequencer
//   ch1_trigger      NR14 write with d[7]=1
//   nr10_period/negate/shift  NR10 fields
//   dp               datapath bundle (master side)
//   ch1_sweep_off    1-cycle request to clear channel-1 enable
//   busy             sequence in progress
// Build option: CH1_SWEEP_NEG_QUIRK_EN - clearing negate after a
// subtract-mode calculation disables the channel.
module ch1_sweep_ctl
  import apu_pkg::*;
#(
  parameter int PERIOD_W = 3,
  parameter int SHIFT_W  = 3
) (
  input  logic                clk,
  input  logic                apu_reset,
  input  logic                sweep_tick,
  input  logic                ch1_trigger,
  input  logic [PERIOD_W-1:0] nr10_period,
  input  logic                nr10_negate,
  input  logic [SHIFT_W-1:0]  nr10_shift,
  ch1_sweep_ctl_if.master     dp,
  output logic                ch1_sweep_off,
  output logic                busy
);
  sweep_state_t       state;
  sweep_mode_t        mode;
  logic [SHIFT_W-1:0] bit_cnt;
  logic               n_nz;
  logic               sweep_en, tick_pend;
  logic               ld_q, sclk_q, upd_q, off_q, busy_q;
  logic               tick_svc, expire, start_calc;

`ifdef CH1_SWEEP_NEG_QUIRK_EN
  logic neg_used, neg_prev;
`else
  // Negate only steers the datapath adder in this build.
  logic negate_unused;
  assign negate_unused = nr10_negate;
`endif

  // Ticks (fresh or pending) are only serviced while idle; trigger wins.
  assign tick_svc   = ~ch1_trigger & (state == IDLE) & (sweep_tick | tick_pend);
  assign start_calc = tick_svc & expire & sweep_en & (nr10_period != '0);

  sweep_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk       (clk),
    .apu_reset (apu_reset),
    .load      (ch1_trigger),
    .step      (tick_svc),
    .period    (nr10_period),
    .expire    (expire)
  );

  always_ff @(posedge clk) begin
    if (apu_reset) begin
      state <= IDLE;   mode <= CALC;   bit_cnt <= '0;  n_nz <= 1'b0;
      sweep_en <= 1'b0; tick_pend <= 1'b0;
      ld_q <= 1'b0; sclk_q <= 1'b0; upd_q <= 1'b0; off_q <= 1'b0; busy_q <= 1'b0;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
      neg_used <= 1'b0; neg_prev <= 1'b0;
`endif
    end else begin
      ld_q  <= 1'b0;
      upd_q <= 1'b0;
      off_q <= 1'b0;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
      neg_prev <= nr10_negate;
`endif
      if (ch1_trigger) begin
        // Abort anything in flight and restart from the trigger rules.
        sclk_q    <= 1'b0;
        tick_pend <= 1'b0;
        sweep_en  <= (nr10_period != '0) | (nr10_shift != '0);
`ifdef CH1_SWEEP_NEG_QUIRK_EN
        neg_used  <= 1'b0;
`endif
        if (nr10_shift != '0) begin
          state <= LOAD; mode <= CHECK_ONLY; ld_q <= 1'b1; busy_q <= 1'b1;
        end else begin
          state <= IDLE; busy_q <= 1'b0;
        end
      end else begin
        if (sweep_tick && state != IDLE) tick_pend <= 1'b1;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
        if (neg_prev && !nr10_negate && neg_used && sweep_en) begin
          off_q    <= 1'b1;
          sweep_en <= 1'b0;
        end
`endif
        case (state)
          IDLE: begin
            tick_pend <= 1'b0;
            if (start_calc) begin
              state <= LOAD; mode <= CALC; ld_q <= 1'b1; busy_q <= 1'b1;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
              if (nr10_negate) neg_used <= 1'b1;
`endif
            end
          end
          LOAD: begin
            // Shift count is frozen here for the rest of the sequence.
            bit_cnt <= nr10_shift;
            n_nz    <= (nr10_shift != '0);
            if (nr10_shift != '0) begin
              state <= SHIFT; sclk_q <= 1'b1;
            end else begin
              state <= CHECK;
            end
          end
          SHIFT: begin
            // bit_cnt counts bits still owed, including the one just clocked.
            if (sclk_q)                      sclk_q <= 1'b0;
            else if (bit_cnt > SHIFT_W'(1)) begin
              bit_cnt <= bit_cnt - SHIFT_W'(1);
              sclk_q  <= 1'b1;
            end else                         state <= CHECK;
          end
          CHECK: begin
            if (!dp.sum_ok) begin
              off_q <= 1'b1; sweep_en <= 1'b0; state <= IDLE; busy_q <= 1'b0;
            end else if (mode == CALC && n_nz) begin
              state <= UPDATE; upd_q <= 1'b1;
            end else begin
              state <= IDLE; busy_q <= 1'b0;
            end
          end
          UPDATE: begin
            state <= IDLE; busy_q <= 1'b0;
          end
          default: begin
            state <= IDLE; busy_q <= 1'b0; sclk_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // A trigger kills every output in its own cycle, not one cycle later.
  assign dp.ch1_ld_shift  = ld_q   & ~ch1_trigger;
  assign dp.ch1_shift_clk = sclk_q & ~ch1_trigger;
  assign dp.ch1_freq_upd1 = upd_q  & ~ch1_trigger;
  assign dp.ch1_freq_upd2 = upd_q  & ~ch1_trigger;
  assign ch1_sweep_off    = off_q  & ~ch1_trigger;
  assign busy             = busy_q & ~ch1_trigger;
endmodule

// File: tb/tb_ch1_sweep_ctl.sv
// Testbench for ch1_sweep_ctl: per-cycle vector table built from small
// scenario descriptions; expected outputs go through a scoreboard queue.
// Honours CH1_SWEEP_NEG_QUIRK_EN for the negate-clear scenario.
module tb_ch1_sweep_ctl;
  logic       clk = 1'b0;
  logic       apu_reset, sweep_tick, ch1_trigger, nr10_negate;
  logic [2:0] nr10_period, nr10_shift;
  logic       sweep_off, busy;

  always #5 clk = ~clk;

  ch1_sweep_ctl_if dp();

  ch1_sweep_ctl dut (
    .clk           (clk),
    .apu_reset     (apu_reset),
    .sweep_tick    (sweep_tick),
    .ch1_trigger   (ch1_trigger),
    .nr10_period   (nr10_period),
    .nr10_negate   (nr10_negate),
    .nr10_shift    (nr10_shift),
    .dp            (dp),
    .ch1_sweep_off (sweep_off),
    .busy          (busy)
  );

  // Output vector: {busy, sweep_off, upd2, upd1, shift_clk, ld_shift}
  localparam bit [5:0] O_LD = 6'b000001, O_SC = 6'b000010, O_U1 = 6'b000100,
                       O_U2 = 6'b001000, O_OFF = 6'b010000, O_BSY = 6'b100000;

  typedef struct {
    bit       rst, trig, tick, neg, ok;
    bit [2:0] per, sh;
    bit [5:0] exp;
    string    tag;
  } vec_t;

  vec_t     tv[$];
  vec_t     sc[0:39];
  int       sc_len;
  bit [5:0] exp_q[$];
  string    tag_q[$];
  int       row_q[$];
  int       n_chk = 0;
  int       n_fail = 0;

  task automatic scn_begin(input string tag, input bit [2:0] per, input bit [2:0] sh,
                           input bit neg, input int len);
    sc_len = len;
    for (int i = 0; i < 40; i++) begin
      sc[i].rst = 0; sc[i].trig = 0; sc[i].tick = 0; sc[i].neg = neg; sc[i].ok = 1;
      sc[i].per = per; sc[i].sh = sh; sc[i].exp = '0; sc[i].tag = tag;
    end
  endtask

  // Expected timeline of one sequence whose LOAD cycle is t0.
  task automatic put_seq(input int t0, input int n, input bit upd, input bit fail);
    int c;
    sc[t0].exp |= O_LD | O_BSY;
    for (int i = 0; i < n; i++) begin
      sc[t0 + 1 + 2*i].exp |= O_SC | O_BSY;
      sc[t0 + 2 + 2*i].exp |= O_BSY;
    end
    c = t0 + 1 + 2*n;
    sc[c].exp |= O_BSY;
    if (fail)     sc[c+1].exp |= O_OFF;
    else if (upd) sc[c+1].exp |= O_U1 | O_U2 | O_BSY;
  endtask

  task automatic clr_from(input int c);
    for (int i = c; i < 40; i++) sc[i].exp = '0;
  endtask

  // Two checked reset rows, then the scenario; trigger cycles show all-zero.
  task automatic scn_end();
    vec_t r;
    r = sc[0]; r.rst = 1; r.trig = 0; r.tick = 0; r.exp = '0; r.tag = "reset";
    tv.push_back(r); tv.push_back(r);
    for (int i = 0; i < sc_len; i++) begin
      if (sc[i].trig) sc[i].exp = '0;
      tv.push_back(sc[i]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      bit [5:0] e, got;
      string    t;
      int       r;
      e = exp_q.pop_front(); t = tag_q.pop_front(); r = row_q.pop_front();
      got = {busy, sweep_off, dp.ch1_freq_upd2, dp.ch1_freq_upd1,
             dp.ch1_shift_clk, dp.ch1_ld_shift};
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s row %0d: outputs {bsy,off,u2,u1,sclk,ld} got %b expected %b",
                 t, r, got, e);
      end
    end
  end

  initial begin
    apu_reset = 1; sweep_tick = 0; ch1_trigger = 0; nr10_negate = 0;
    nr10_period = 0; nr10_shift = 0; dp.sum_ok = 1;

    // Trigger, period 2, n 1: check-only, no write-back.
    scn_begin("trig_chk_n1", 3'd2, 3'd1, 0, 8);
    sc[0].trig = 1; put_seq(1, 1, 0, 0); scn_end();

    // Second tick expires the timer; update 9 cycles after that tick.
    scn_begin("tick_calc_n3", 3'd2, 3'd3, 0, 24);
    sc[0].trig = 1; sc[10].tick = 1; sc[12].tick = 1;
    put_seq(1, 3, 0, 0); put_seq(13, 3, 1, 0); scn_end();

    // Overflow on a calc sequence disables; later expiries start nothing.
    scn_begin("overflow_off", 3'd1, 3'd2, 0, 22);
    sc[0].trig = 1; sc[8].tick = 1; sc[17].tick = 1; sc[19].tick = 1;
    for (int i = 8; i < 22; i++) sc[i].ok = 0;
    put_seq(1, 2, 0, 0); put_seq(9, 2, 0, 1); scn_end();

    // Period 0: check sequence on trigger, then 8 ticks start nothing.
    scn_begin("period0", 3'd0, 3'd5, 0, 31);
    sc[0].trig = 1;
    for (int k = 0; k < 8; k++) sc[14 + 2*k].tick = 1;
    put_seq(1, 5, 0, 0); scn_end();

    // Ticks during SHIFT: one is held and serviced on the first idle cycle.
    scn_begin("tick_pend", 3'd1, 3'd2, 0, 17);
    sc[0].trig = 1; sc[3].tick = 1; sc[4].tick = 1;
    put_seq(1, 2, 0, 0); put_seq(8, 2, 1, 0); scn_end();

    // Trigger (with a simultaneous tick) aborts a calc in SHIFT; the pending
    // and simultaneous ticks are discarded, so the tick at 23 only counts down.
    scn_begin("trig_abort", 3'd2, 3'd2, 0, 27);
    sc[0].trig = 1; sc[8].tick = 1; sc[10].tick = 1; sc[12].tick = 1;
    sc[14].trig = 1; sc[14].tick = 1; sc[23].tick = 1;
    put_seq(1, 2, 0, 0); put_seq(11, 2, 1, 0); clr_from(14); put_seq(15, 2, 0, 0);
    scn_end();

    // Reset during a shift_clk high cycle: next cycle idle, enable cleared.
    scn_begin("reset_mid", 3'd3, 3'd7, 0, 11);
    sc[0].trig = 1; sc[4].rst = 1; sc[8].tick = 1;
    put_seq(1, 7, 0, 0); clr_from(5); scn_end();

    // Subtract-mode calc, then negate cleared at cycle 13.
    scn_begin("neg_clear", 3'd1, 3'd1, 1, 24);
    sc[0].trig = 1; sc[6].tick = 1; sc[16].tick = 1;
    for (int i = 13; i < 24; i++) sc[i].neg = 0;
    put_seq(1, 1, 0, 0); put_seq(7, 1, 1, 0);
`ifdef CH1_SWEEP_NEG_QUIRK_EN
    sc[14].exp |= O_OFF;
`else
    put_seq(17, 1, 1, 0);
`endif
    scn_end();

    repeat (2) @(posedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk); #1;
      apu_reset   = tv[i].rst;
      ch1_trigger = tv[i].trig;
      sweep_tick  = tv[i].tick;
      nr10_negate = tv[i].neg;
      nr10_period = tv[i].per;
      nr10_shift  = tv[i].sh;
      dp.sum_ok   = tv[i].ok;
      exp_q.push_back(tv[i].exp); tag_q.push_back(tv[i].tag); row_q.push_back(i);
    end
    @(posedge clk); #1;
    ch1_trigger = 0; sweep_tick = 0;
    @(negedge clk); @(posedge clk); #1;

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
